// File: rtl/qed_dup_scheduler.sv
// QED fetch-side scheduler: forwards original instructions while queueing them,
// then replays the queue as duplicates and flags when both halves have retired equally.
module qed_dup_scheduler #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int INSN_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              qed_exec_dup,
    input  logic              ifu_valid,
    input  logic [INSN_W-1:0] ifu_insn,
    output logic              ifu_ready,
    output logic              core_valid,
    output logic [INSN_W-1:0] core_insn,
    output logic              core_is_dup,
    input  logic              core_ready,
    input  logic              commit,
    input  logic              commit_is_dup,
    output logic [CNT_W-1:0]  qed_num_orig,
    output logic [CNT_W-1:0]  qed_num_dup,
    output logic [1:0]        sif_state,
    output logic [ADDR_W:0]   q_count,
    output logic              qed_ready
);

    typedef enum logic [1:0] {
        S_ORIG = 2'd0,
        S_DUP  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [INSN_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_count;
    logic [CNT_W-1:0]  r_num_orig;
    logic [CNT_W-1:0]  r_num_dup;
    logic              r_qed_ready;

    logic w_full;
    logic w_empty;
    logic w_in_orig;
    logic w_in_dup;
    logic w_push;
    logic w_pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Handshake outputs are gated by resetn so nothing is offered or accepted while reset is held.
    assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_in_orig = resetn && (r_state == S_ORIG);
    assign w_in_dup  = resetn && (r_state == S_DUP);

    assign ifu_ready   = w_in_orig && core_ready && !w_full && !qed_exec_dup;
    assign core_valid  = (w_in_orig && ifu_valid && !qed_exec_dup) || w_in_dup;
    assign core_insn   = (r_state == S_DUP) ? r_mem[r_head] : ifu_insn;
    assign core_is_dup = w_in_dup;
    assign w_push      = ifu_valid && ifu_ready;
    assign w_pop       = w_in_dup && core_ready;

    assign qed_num_orig = r_num_orig;
    assign qed_num_dup  = r_num_dup;
    assign sif_state    = r_state;
    assign q_count      = r_count;
    assign qed_ready    = r_qed_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= ifu_insn;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_ORIG;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_num_orig  <= '0;
            r_num_dup   <= '0;
            r_qed_ready <= 1'b0;
        end else begin
            if (commit && !commit_is_dup) begin
                r_num_orig <= sat_inc(r_num_orig);
            end
            if (commit && commit_is_dup) begin
                r_num_dup <= sat_inc(r_num_dup);
            end

            case (r_state)
                S_ORIG: begin
                    if (w_push) begin
                        r_tail  <= r_tail + 1'b1;
                        r_count <= r_count + 1'b1;
                    end
                    if (qed_exec_dup && !w_empty) begin
                        r_state <= S_DUP;
                    end
                end
                S_DUP: begin
                    if (w_pop) begin
                        r_head  <= r_head + 1'b1;
                        r_count <= r_count - 1'b1;
                        if (r_count == (ADDR_W+1)'(1)) begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_num_orig == r_num_dup) begin
                        r_state     <= S_DONE;
                        r_qed_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Directed bench for qed_dup_scheduler; a second instance with CNT_W=4 covers saturation.
module tb_qed_dup_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        qed_exec_dup;
    logic        ifu_valid;
    logic [31:0] ifu_insn;
    logic        ifu_ready;
    logic        core_valid;
    logic [31:0] core_insn;
    logic        core_is_dup;
    logic        core_ready;
    logic        commit;
    logic        commit_is_dup;
    logic [15:0] qed_num_orig;
    logic [15:0] qed_num_dup;
    logic [1:0]  sif_state;
    logic [4:0]  q_count;
    logic        qed_ready;

    logic        s_ifu_ready;
    logic        s_core_valid;
    logic [31:0] s_core_insn;
    logic        s_core_is_dup;
    logic [3:0]  s_num_orig;
    logic [3:0]  s_num_dup;
    logic [1:0]  s_state;
    logic [4:0]  s_q_count;
    logic        s_qed_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] bv [3];

    always #5 clk = ~clk;

    qed_dup_scheduler #(.DEPTH(16), .ADDR_W(4), .INSN_W(32), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .qed_exec_dup(qed_exec_dup),
        .ifu_valid(ifu_valid), .ifu_insn(ifu_insn), .ifu_ready(ifu_ready),
        .core_valid(core_valid), .core_insn(core_insn), .core_is_dup(core_is_dup),
        .core_ready(core_ready), .commit(commit), .commit_is_dup(commit_is_dup),
        .qed_num_orig(qed_num_orig), .qed_num_dup(qed_num_dup),
        .sif_state(sif_state), .q_count(q_count), .qed_ready(qed_ready)
    );

    qed_dup_scheduler #(.DEPTH(16), .ADDR_W(4), .INSN_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .qed_exec_dup(qed_exec_dup),
        .ifu_valid(ifu_valid), .ifu_insn(ifu_insn), .ifu_ready(s_ifu_ready),
        .core_valid(s_core_valid), .core_insn(s_core_insn), .core_is_dup(s_core_is_dup),
        .core_ready(core_ready), .commit(commit), .commit_is_dup(commit_is_dup),
        .qed_num_orig(s_num_orig), .qed_num_dup(s_num_dup),
        .sif_state(s_state), .q_count(s_q_count), .qed_ready(s_qed_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        qed_exec_dup  = 1'b0;
        ifu_valid     = 1'b0;
        ifu_insn      = '0;
        core_ready    = 1'b1;
        commit        = 1'b0;
        commit_is_dup = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; qed_exec_dup = 1'b0; ifu_valid = 1'b1; ifu_insn = 32'hABCD;
        core_ready = 1'b1; commit = 1'b0; commit_is_dup = 1'b0;
        #2;
        n_checks++; if (ifu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ifu_ready: got %0d want 0", ifu_ready); end
        n_checks++; if (core_valid !== 1'b0) begin n_fail++; $display("FAIL rst_core_valid: got %0d want 0", core_valid); end
        n_checks++; if (core_is_dup !== 1'b0) begin n_fail++; $display("FAIL rst_core_is_dup: got %0d want 0", core_is_dup); end
        tick(); tick();
        n_checks++; if ({qed_num_orig, qed_num_dup} !== 32'd0) begin n_fail++; $display("FAIL rst_counters: got %0d/%0d want 0/0", qed_num_orig, qed_num_dup); end
        n_checks++; if (sif_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", sif_state); end
        n_checks++; if (q_count !== 5'd0) begin n_fail++; $display("FAIL rst_q_count: got %0d want 0", q_count); end
        n_checks++; if (qed_ready !== 1'b0) begin n_fail++; $display("FAIL rst_qed_ready: got %0d want 0", qed_ready); end
        resetn = 1'b1;
        #1;
        n_checks++; if (ifu_ready !== 1'b1 || core_valid !== 1'b1) begin n_fail++; $display("FAIL rel_handshake: got ready=%0d valid=%0d want 1/1", ifu_ready, core_valid); end
        n_checks++; if (core_insn !== 32'hABCD) begin n_fail++; $display("FAIL rel_passthrough: got %0h want abcd", core_insn); end
        tick();
        ifu_valid = 1'b0;
        n_checks++; if (q_count !== 5'd1) begin n_fail++; $display("FAIL rel_first_push: got %0d want 1", q_count); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ifu_valid = 1'b1; ifu_insn = bv[i]; commit = 1'b1; commit_is_dup = 1'b0;
            tick();
        end
        ifu_valid = 1'b0; commit = 1'b0;
        n_checks++; if (q_count !== 5'd3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", q_count); end
        qed_exec_dup = 1'b1; ifu_valid = 1'b1;
        #1;
        n_checks++; if (core_valid !== 1'b0 || ifu_ready !== 1'b0) begin n_fail++; $display("FAIL basic_switch_stall: got valid=%0d ready=%0d want 0/0", core_valid, ifu_ready); end
        tick();
        qed_exec_dup = 1'b0; ifu_valid = 1'b0;
        n_checks++; if (sif_state !== 2'd1) begin n_fail++; $display("FAIL basic_state_dup: got %0d want 1", sif_state); end
        n_checks++; if (q_count !== 5'd3) begin n_fail++; $display("FAIL basic_no_push_on_switch: got %0d want 3", q_count); end
        commit = 1'b1; commit_is_dup = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (core_valid !== 1'b1 || core_is_dup !== 1'b1 || core_insn !== bv[i]) begin
                n_fail++; $display("FAIL basic_replay%0d: got v=%0d d=%0d insn=%0h want 1/1/%0h", i, core_valid, core_is_dup, core_insn, bv[i]);
            end
            tick();
        end
        commit = 1'b0; commit_is_dup = 1'b0;
        n_checks++; if (sif_state !== 2'd2) begin n_fail++; $display("FAIL basic_state_wait: got %0d want 2", sif_state); end
        n_checks++; if (qed_num_orig !== 16'd3 || qed_num_dup !== 16'd3) begin n_fail++; $display("FAIL basic_counts: got %0d/%0d want 3/3", qed_num_orig, qed_num_dup); end
        n_checks++; if (qed_ready !== 1'b0 || core_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_outputs: got rdy=%0d valid=%0d want 0/0", qed_ready, core_valid); end
        tick();
        n_checks++; if (sif_state !== 2'd3 || qed_ready !== 1'b1) begin n_fail++; $display("FAIL basic_done: got state=%0d rdy=%0d want 3/1", sif_state, qed_ready); end
    endtask

    task automatic test_full_queue();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ifu_valid = 1'b1; ifu_insn = 32'h1000 + i;
            commit = (i == 0); commit_is_dup = 1'b0;
            tick();
        end
        commit = 1'b0;
        ifu_insn = 32'hDEAD;
        #1;
        n_checks++; if (q_count !== 5'd16 || ifu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got count=%0d ready=%0d want 16/0", q_count, ifu_ready); end
        tick();
        n_checks++; if (q_count !== 5'd16) begin n_fail++; $display("FAIL full_no_overflow: got %0d want 16", q_count); end
        ifu_valid = 1'b0; qed_exec_dup = 1'b1;
        tick();
        qed_exec_dup = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (core_insn !== 32'h1000 + i || core_is_dup !== 1'b1) begin
                n_fail++; $display("FAIL full_replay%0d: got %0h dup=%0d want %0h/1", i, core_insn, core_is_dup, 32'h1000 + i);
            end
            tick();
        end
        n_checks++; if (sif_state !== 2'd2 || q_count !== 5'd0) begin n_fail++; $display("FAIL full_wait: got state=%0d count=%0d want 2/0", sif_state, q_count); end
        tick();
        n_checks++; if (sif_state !== 2'd2 || qed_ready !== 1'b0) begin n_fail++; $display("FAIL full_wait_hold: got state=%0d rdy=%0d want 2/0", sif_state, qed_ready); end
        commit = 1'b1; commit_is_dup = 1'b1;
        tick();
        commit = 1'b0; commit_is_dup = 1'b0;
        n_checks++; if (sif_state !== 2'd2 || qed_num_dup !== 16'd1) begin n_fail++; $display("FAIL full_equal_cycle: got state=%0d dup=%0d want 2/1", sif_state, qed_num_dup); end
        tick();
        n_checks++; if (sif_state !== 2'd3 || qed_ready !== 1'b1) begin n_fail++; $display("FAIL full_done: got state=%0d rdy=%0d want 3/1", sif_state, qed_ready); end
    endtask

    task automatic test_empty_switch();
        do_reset();
        ifu_valid = 1'b1; ifu_insn = 32'h55; core_ready = 1'b1; qed_exec_dup = 1'b1;
        #1;
        n_checks++; if (ifu_ready !== 1'b0 || core_valid !== 1'b0) begin n_fail++; $display("FAIL empty_stall: got ready=%0d valid=%0d want 0/0", ifu_ready, core_valid); end
        tick();
        n_checks++; if (sif_state !== 2'd0 || q_count !== 5'd0) begin n_fail++; $display("FAIL empty_stay_orig: got state=%0d count=%0d want 0/0", sif_state, q_count); end
        qed_exec_dup = 1'b0; ifu_valid = 1'b0;
    endtask

    task automatic test_backpressure_and_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ifu_valid = 1'b1; ifu_insn = 32'hA0 + i; commit = 1'b1; commit_is_dup = 1'b0;
            tick();
        end
        ifu_valid = 1'b0; commit = 1'b0; qed_exec_dup = 1'b1;
        tick();
        qed_exec_dup = 1'b0; core_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (core_insn !== 32'hA0 || q_count !== 5'd3 || sif_state !== 2'd1 || core_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold%0d: got insn=%0h count=%0d state=%0d valid=%0d want a0/3/1/1", i, core_insn, q_count, sif_state, core_valid);
            end
            tick();
        end
        core_ready = 1'b1;
        tick();
        n_checks++; if (core_insn !== 32'hA1 || q_count !== 5'd2) begin n_fail++; $display("FAIL bp_resume: got insn=%0h count=%0d want a1/2", core_insn, q_count); end
        resetn = 1'b0;
        #2;
        n_checks++; if (sif_state !== 2'd0 || q_count !== 5'd0 || qed_num_orig !== 16'd0 || qed_num_dup !== 16'd0) begin
            n_fail++; $display("FAIL async_reset: got state=%0d count=%0d orig=%0d dup=%0d want 0/0/0/0", sif_state, q_count, qed_num_orig, qed_num_dup);
        end
        n_checks++; if (core_valid !== 1'b0 || core_is_dup !== 1'b0) begin n_fail++; $display("FAIL async_reset_outputs: got valid=%0d dup=%0d want 0/0", core_valid, core_is_dup); end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        commit = 1'b1; commit_is_dup = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        commit = 1'b0;
        n_checks++; if (s_num_orig !== 4'd15) begin n_fail++; $display("FAIL sat_orig4: got %0d want 15", s_num_orig); end
        n_checks++; if (qed_num_orig !== 16'd20) begin n_fail++; $display("FAIL sat_orig16: got %0d want 20", qed_num_orig); end
        commit = 1'b1; commit_is_dup = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        commit = 1'b0; commit_is_dup = 1'b0;
        n_checks++; if (s_num_dup !== 4'd15 || s_num_orig !== 4'd15) begin n_fail++; $display("FAIL sat_dup4: got dup=%0d orig=%0d want 15/15", s_num_dup, s_num_orig); end
    endtask

    initial begin
        bv[0] = 32'h13; bv[1] = 32'h93; bv[2] = 32'h113;
        test_reset();
        test_basic();
        test_full_queue();
        test_empty_switch();
        test_backpressure_and_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
